// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU op one-hot indices, memory size
// encodings, exception bit positions and the EXE->MEM bus width.
package exe_stage_pkg;

  localparam int unsigned AluOpW  = 12;
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluOr   = 5;
  localparam int unsigned AluNor  = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef enum logic [1:0] {
    MemNone = 2'b00,
    MemByte = 2'b01,
    MemHalf = 2'b10,
    MemWord = 2'b11
  } mem_size_e;

  localparam int unsigned ExcpW    = 6;
  localparam int unsigned ExcpAle  = 1;
  localparam int unsigned ExcpIne  = 2;
  localparam int unsigned ExcpBrk  = 3;
  localparam int unsigned ExcpSys  = 4;
  localparam int unsigned ExcpAdef = 5;

  // result + excp + pc + mem_size + we + re
  function automatic int unsigned exe_to_mem_wd(input int unsigned excp_w);
    return 32 + excp_w + 32 + 2 + 1 + 1;
  endfunction

  localparam int unsigned ExeToMemWd = exe_to_mem_wd(ExcpW);

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with a one-hot operation select.
module exe_stage_alu
  import exe_stage_pkg::*;
#(
  parameter int unsigned ALU_OP_W = AluOpW
) (
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [31:0]         src1_i,
  input  logic [31:0]         src2_i,
  output logic [31:0]         result_o
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign add_res  = src1_i + src2_i;
  assign sub_res  = src1_i - src2_i;
  assign slt_res  = $signed(src1_i) < $signed(src2_i);
  assign sltu_res = src1_i < src2_i;
  assign sll_res  = src1_i << src2_i[4:0];
  assign srl_res  = src1_i >> src2_i[4:0];
  assign sra_res  = $unsigned($signed(src1_i) >>> src2_i[4:0]);

  always_comb begin
    result_o = ({32{alu_op_i[AluAdd]}}  & add_res)
             | ({32{alu_op_i[AluSub]}}  & sub_res)
             | ({32{alu_op_i[AluSlt]}}  & {31'd0, slt_res})
             | ({32{alu_op_i[AluSltu]}} & {31'd0, sltu_res})
             | ({32{alu_op_i[AluAnd]}}  & (src1_i & src2_i))
             | ({32{alu_op_i[AluOr]}}   & (src1_i | src2_i))
             | ({32{alu_op_i[AluNor]}}  & ~(src1_i | src2_i))
             | ({32{alu_op_i[AluXor]}}  & (src1_i ^ src2_i))
             | ({32{alu_op_i[AluSll]}}  & sll_res)
             | ({32{alu_op_i[AluSrl]}}  & srl_res)
             | ({32{alu_op_i[AluSra]}}  & sra_res)
             | ({32{alu_op_i[AluLui]}}  & src2_i);
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, load/store address generation, ALE detection and the
// data-SRAM request handshake, with flush handling from MEM.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 12,
  parameter int unsigned EXCP_W   = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                id_to_exe_valid,
  output logic                exe_allowin,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [31:0]         id_src1,
  input  logic [31:0]         id_src2,
  input  logic [31:0]         id_st_data,
  input  logic [1:0]          id_mem_size,
  input  logic                id_mem_we,
  input  logic                id_mem_re,
  input  logic [EXCP_W-1:0]   id_excp,
  input  logic                id_ertn,
  input  logic [31:0]         id_pc,
  input  logic                mem_allowin,
  output logic                exe_to_mem_valid,
  output logic [31:0]         exe_result,
  output logic [EXCP_W-1:0]   exe_excp,
  output logic [31:0]         exe_pc,
  output logic [1:0]          exe_mem_size,
  output logic                exe_mem_we,
  output logic                exe_mem_re,
  input  logic                mem_flush,
  input  logic                mem_excp_pending,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [3:0]          data_sram_wstrb,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic                data_sram_addr_ok,
  output logic                exe_req_cancel
);

  localparam int unsigned BusW = exe_to_mem_wd(EXCP_W);

  logic                exe_valid_q, exe_valid_d;
  logic                req_issued_q, req_issued_d;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic [31:0]         src1_q, src2_q, st_data_q, pc_q;
  logic [1:0]          mem_size_q;
  logic                mem_we_q, mem_re_q, ertn_q;
  logic [EXCP_W-1:0]   excp_q;

  logic [31:0]       alu_result;
  logic              mem_op, ale, exe_ready_go, capture;
  logic [EXCP_W-1:0] ale_vec, excp_merged;
  logic [BusW-1:0]   exe_to_mem_bus;

  exe_stage_alu #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu (
    .alu_op_i (alu_op_q),
    .src1_i   (src1_q),
    .src2_i   (src2_q),
    .result_o (alu_result)
  );

  assign mem_op = mem_we_q | mem_re_q;
  assign ale    = mem_op & (((mem_size_q == MemHalf) & alu_result[0]) |
                            ((mem_size_q == MemWord) & (alu_result[1:0] != 2'b00)));

  always_comb begin
    ale_vec          = '0;
    ale_vec[ExcpAle] = ale;
  end
  assign excp_merged = excp_q | ale_vec;

  // Request only for clean memory ops; a flush or older excp in MEM kills it the same cycle.
  assign data_sram_req = exe_valid_q & mem_op & ~ale & ~(|excp_q) & ~ertn_q & ~mem_flush &
                         ~mem_excp_pending & ~req_issued_q;

  assign exe_ready_go     = ~mem_op | (|excp_merged) | ertn_q | req_issued_q |
                            (data_sram_req & data_sram_addr_ok);
  assign exe_allowin      = ~exe_valid_q | (exe_ready_go & mem_allowin);
  assign exe_to_mem_valid = exe_valid_q & exe_ready_go & ~mem_flush;
  assign exe_req_cancel   = mem_flush & exe_valid_q & req_issued_q;
  assign capture          = exe_allowin & id_to_exe_valid;

  always_comb begin
    exe_valid_d = exe_valid_q;
    if (mem_flush) begin
      exe_valid_d = 1'b0;
    end else if (exe_allowin) begin
      exe_valid_d = id_to_exe_valid;
    end
  end

  always_comb begin
    req_issued_d = req_issued_q;
    if (mem_flush || (exe_valid_q && exe_ready_go && mem_allowin)) begin
      req_issued_d = 1'b0;
    end else if (data_sram_req && data_sram_addr_ok) begin
      req_issued_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_q  <= 1'b0;
      req_issued_q <= 1'b0;
      alu_op_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      st_data_q    <= '0;
      pc_q         <= '0;
      mem_size_q   <= MemNone;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      ertn_q       <= 1'b0;
      excp_q       <= '0;
    end else begin
      exe_valid_q  <= exe_valid_d;
      req_issued_q <= req_issued_d;
      if (capture) begin
        alu_op_q   <= id_alu_op;
        src1_q     <= id_src1;
        src2_q     <= id_src2;
        st_data_q  <= id_st_data;
        pc_q       <= id_pc;
        mem_size_q <= id_mem_size;
        mem_we_q   <= id_mem_we;
        mem_re_q   <= id_mem_re;
        ertn_q     <= id_ertn;
        excp_q     <= id_excp;
      end
    end
  end

  always_comb begin
    data_sram_wdata = st_data_q;
    data_sram_wstrb = 4'b0000;
    data_sram_size  = 2'd0;
    case (mem_size_q)
      MemByte: begin
        data_sram_wdata = {4{st_data_q[7:0]}};
        data_sram_wstrb = 4'b0001 << alu_result[1:0];
        data_sram_size  = 2'd0;
      end
      MemHalf: begin
        data_sram_wdata = {2{st_data_q[15:0]}};
        data_sram_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
        data_sram_size  = 2'd1;
      end
      MemWord: begin
        data_sram_wstrb = 4'b1111;
        data_sram_size  = 2'd2;
      end
      default: ;
    endcase
    if (!mem_we_q) data_sram_wstrb = 4'b0000;
  end

  assign data_sram_wr   = mem_we_q;
  assign data_sram_addr = alu_result;

  assign exe_to_mem_bus = {alu_result, excp_merged, pc_q, mem_size_q, mem_we_q, mem_re_q};
  assign {exe_result, exe_excp, exe_pc, exe_mem_size, exe_mem_we, exe_mem_re} = exe_to_mem_bus;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized
// single-cycle traffic against a behavioural reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_to_exe_valid;
  logic        exe_allowin;
  logic [11:0] id_alu_op;
  logic [31:0] id_src1, id_src2, id_st_data, id_pc;
  logic [1:0]  id_mem_size;
  logic        id_mem_we, id_mem_re, id_ertn;
  logic [5:0]  id_excp;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [31:0] exe_result, exe_pc;
  logic [5:0]  exe_excp;
  logic [1:0]  exe_mem_size;
  logic        exe_mem_we, exe_mem_re;
  logic        mem_flush, mem_excp_pending;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        exe_req_cancel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_stage #(
    .ALU_OP_W (12),
    .EXCP_W   (6)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .id_to_exe_valid   (id_to_exe_valid),
    .exe_allowin       (exe_allowin),
    .id_alu_op         (id_alu_op),
    .id_src1           (id_src1),
    .id_src2           (id_src2),
    .id_st_data        (id_st_data),
    .id_mem_size       (id_mem_size),
    .id_mem_we         (id_mem_we),
    .id_mem_re         (id_mem_re),
    .id_excp           (id_excp),
    .id_ertn           (id_ertn),
    .id_pc             (id_pc),
    .mem_allowin       (mem_allowin),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_result        (exe_result),
    .exe_excp          (exe_excp),
    .exe_pc            (exe_pc),
    .exe_mem_size      (exe_mem_size),
    .exe_mem_we        (exe_mem_we),
    .exe_mem_re        (exe_mem_re),
    .mem_flush         (mem_flush),
    .mem_excp_pending  (mem_excp_pending),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .exe_req_cancel    (exe_req_cancel)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    case (op)
      0:  r = a + b;
      1:  r = a + ~b + 32'd1;
      2:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      3:  r = {31'd0, a < b};
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a | b);
      7:  r = a ^ b;
      8:  r = a << s;
      9:  r = a >> s;
      10: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic ref_ale(input logic [1:0] size, input logic mem, input logic [31:0] addr);
    if (!mem) return 1'b0;
    if (size == 2'b10) return addr % 2 != 0;
    if (size == 2'b11) return addr % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [1:0] size, input logic we, input logic [31:0] addr);
    if (!we) return 4'b0000;
    case (size)
      2'b01:   return 4'(1 << (addr % 4));
      2'b10:   return (addr % 4 >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] st);
    case (size)
      2'b01:   return (st & 32'hFF) * 32'h0101_0101;
      2'b10:   return (st & 32'hFFFF) * 32'h0001_0001;
      default: return st;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic [1:0] size, input logic we,
                       input logic re, input logic [5:0] excp, input logic ertn);
    id_to_exe_valid = 1'b1;
    id_alu_op       = 12'(1 << op);
    id_src1         = a;
    id_src2         = b;
    id_st_data      = st;
    id_mem_size     = size;
    id_mem_we       = we;
    id_mem_re       = re;
    id_excp         = excp;
    id_ertn         = ertn;
    id_pc           = 32'h1c00_0000 + a;
  endtask

  task automatic idle_id();
    id_to_exe_valid = 1'b0;
    id_alu_op       = '0;
    id_mem_size     = 2'b00;
    id_mem_we       = 1'b0;
    id_mem_re       = 1'b0;
    id_excp         = '0;
    id_ertn         = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", data_sram_req); end
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", exe_to_mem_valid); end
    n_checks++; if (exe_req_cancel !== 1'b0) begin n_fail++; $display("FAIL reset_cancel: got %b want 0", exe_req_cancel); end
    n_checks++; if (exe_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", exe_result); end
    n_checks++; if (exe_excp !== 6'd0) begin n_fail++; $display("FAIL reset_excp: got %h want 0", exe_excp); end
    n_checks++; if (exe_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", exe_allowin); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    int          ops[3]  = '{1, 3, 10};
    logic [31:0] as[3]   = '{32'd5, 32'd1, 32'h8000_0000};
    logic [31:0] bs[3]   = '{32'd7, 32'hFFFF_FFFF, 32'd4};
    logic [31:0] exps[3] = '{32'hFFFF_FFFE, 32'd1, 32'hF800_0000};
    mem_allowin = 1'b1;
    @(posedge clk); #1;
    drive(ops[0], as[0], bs[0], 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (exe_result !== exps[i]) begin n_fail++; $display("FAIL alu_result[%0d]: got %h want %h", i, exe_result, exps[i]); end
      n_checks++; if (exe_to_mem_valid !== 1'b1) begin n_fail++; $display("FAIL alu_to_mem_valid[%0d]: got %b want 1", i, exe_to_mem_valid); end
      n_checks++; if (exe_allowin !== 1'b1) begin n_fail++; $display("FAIL alu_allowin[%0d]: got %b want 1", i, exe_allowin); end
      if (i < 2) drive(ops[i+1], as[i+1], bs[i+1], 0, 2'b00, 0, 0, 0, 0);
      else idle_id();
    end
    @(posedge clk); #1;
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain: got %b want 0", exe_to_mem_valid); end
  endtask

  task automatic test_store_byte();
    int req_cycles = 0;
    @(posedge clk); #1;
    drive(0, 32'h1000, 32'd3, 32'h0000_00AB, 2'b01, 1, 0, 0, 0);
    @(posedge clk); #1;
    idle_id();
    for (int c = 0; c < 4; c++) begin
      data_sram_addr_ok = (c == 3);
      #1;
      if (data_sram_req) req_cycles++;
      n_checks++; if (data_sram_req !== 1'b1) begin n_fail++; $display("FAIL sb_req[%0d]: got %b want 1", c, data_sram_req); end
      n_checks++; if (exe_allowin !== (c == 3)) begin n_fail++; $display("FAIL sb_allowin[%0d]: got %b want %b", c, exe_allowin, c == 3); end
      if (c == 0) begin
        n_checks++; if (data_sram_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb: got %b want 1000", data_sram_wstrb); end
        n_checks++; if (data_sram_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want ababab", data_sram_wdata); end
        n_checks++; if (data_sram_size !== 2'd0) begin n_fail++; $display("FAIL sb_size: got %0d want 0", data_sram_size); end
        n_checks++; if (data_sram_wr !== 1'b1) begin n_fail++; $display("FAIL sb_wr: got %b want 1", data_sram_wr); end
        n_checks++; if (data_sram_addr !== 32'h1003) begin n_fail++; $display("FAIL sb_addr: got %h want 1003", data_sram_addr); end
      end
      @(posedge clk); #1;
    end
    data_sram_addr_ok = 1'b0;
    #1;
    n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL sb_req_after: got %b want 0", data_sram_req); end
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL sb_left: got %b want 0", exe_to_mem_valid); end
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL sb_req_cycles: got %0d want 4", req_cycles); end
  endtask

  task automatic test_ale();
    @(posedge clk); #1;
    drive(0, 32'h1000, 32'd2, 0, 2'b11, 0, 1, 0, 0);
    @(posedge clk); #1;
    idle_id();
    n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL ale_req: got %b want 0", data_sram_req); end
    n_checks++; if (exe_excp !== 6'b000010) begin n_fail++; $display("FAIL ale_excp: got %b want 000010", exe_excp); end
    n_checks++; if (exe_result !== 32'h1002) begin n_fail++; $display("FAIL ale_badv: got %h want 1002", exe_result); end
    n_checks++; if (exe_to_mem_valid !== 1'b1) begin n_fail++; $display("FAIL ale_pass: got %b want 1", exe_to_mem_valid); end
    @(posedge clk); #1;
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL ale_drain: got %b want 0", exe_to_mem_valid); end
  endtask

  task automatic test_back_pressure();
    int txn = 0;
    mem_allowin = 1'b0;
    @(posedge clk); #1;
    drive(0, 32'h1FFC, 32'd4, 0, 2'b11, 0, 1, 0, 0);
    @(posedge clk); #1;
    idle_id();
    data_sram_addr_ok = 1'b1;
    #1;
    if (data_sram_req && data_sram_addr_ok) txn++;
    n_checks++; if (data_sram_req !== 1'b1) begin n_fail++; $display("FAIL bp_req: got %b want 1", data_sram_req); end
    n_checks++; if (exe_allowin !== 1'b0) begin n_fail++; $display("FAIL bp_allowin0: got %b want 0", exe_allowin); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (data_sram_req && data_sram_addr_ok) txn++;
      n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL bp_no_second_req[%0d]: got %b want 0", k, data_sram_req); end
      n_checks++; if (exe_to_mem_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, exe_to_mem_valid); end
      n_checks++; if (exe_result !== 32'h2000) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h want 2000", k, exe_result); end
      n_checks++; if (exe_allowin !== 1'b0) begin n_fail++; $display("FAIL bp_stall[%0d]: got %b want 0", k, exe_allowin); end
    end
    data_sram_addr_ok = 1'b0;
    mem_allowin = 1'b1;
    #1;
    n_checks++; if (exe_allowin !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", exe_allowin); end
    @(posedge clk); #1;
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL bp_left: got %b want 0", exe_to_mem_valid); end
    n_checks++; if (txn != 1) begin n_fail++; $display("FAIL bp_txn_count: got %0d want 1", txn); end
  endtask

  task automatic test_flush_waiting();
    mem_allowin = 1'b1;
    @(posedge clk); #1;
    drive(0, 32'h3000, 32'd8, 0, 2'b11, 0, 1, 0, 0);
    @(posedge clk); #1;
    idle_id();
    n_checks++; if (data_sram_req !== 1'b1) begin n_fail++; $display("FAIL fw_req: got %b want 1", data_sram_req); end
    mem_flush = 1'b1;
    #1;
    n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL fw_req_drop: got %b want 0", data_sram_req); end
    n_checks++; if (exe_req_cancel !== 1'b0) begin n_fail++; $display("FAIL fw_cancel: got %b want 0", exe_req_cancel); end
    @(posedge clk); #1;
    mem_flush = 1'b0;
    #1;
    n_checks++; if (exe_allowin !== 1'b1 || data_sram_req !== 1'b0) begin n_fail++; $display("FAIL fw_cleared: got allowin=%b req=%b want 1/0", exe_allowin, data_sram_req); end
  endtask

  task automatic test_flush_after_accept();
    mem_allowin = 1'b0;
    @(posedge clk); #1;
    drive(0, 32'h3000, 32'd0, 0, 2'b11, 0, 1, 0, 0);
    @(posedge clk); #1;
    idle_id();
    data_sram_addr_ok = 1'b1;
    #1;
    n_checks++; if (data_sram_req !== 1'b1 || exe_req_cancel !== 1'b0) begin n_fail++; $display("FAIL fa_t: got req=%b cancel=%b want 1/0", data_sram_req, exe_req_cancel); end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    mem_flush = 1'b1;
    #1;
    n_checks++; if (exe_req_cancel !== 1'b1) begin n_fail++; $display("FAIL fa_cancel: got %b want 1", exe_req_cancel); end
    n_checks++; if (exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fa_to_mem: got %b want 0", exe_to_mem_valid); end
    @(posedge clk); #1;
    mem_flush = 1'b0;
    #1;
    n_checks++; if (exe_req_cancel !== 1'b0) begin n_fail++; $display("FAIL fa_cancel_pulse: got %b want 0", exe_req_cancel); end
    n_checks++; if (exe_allowin !== 1'b1 || exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fa_valid_cleared: got allowin=%b to_mem=%b want 1/0", exe_allowin, exe_to_mem_valid); end
    mem_allowin = 1'b1;
  endtask

  task automatic test_async_reset();
    mem_allowin = 1'b0;
    @(posedge clk); #1;
    drive(0, 32'h4000, 32'd0, 32'hDEAD_BEEF, 2'b11, 1, 0, 0, 0);
    @(posedge clk); #1;
    idle_id();
    n_checks++; if (data_sram_req !== 1'b1) begin n_fail++; $display("FAIL ar_req_before: got %b want 1", data_sram_req); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", data_sram_req); end
    n_checks++; if (exe_allowin !== 1'b1 || exe_to_mem_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got allowin=%b to_mem=%b want 1/0", exe_allowin, exe_to_mem_valid); end
    #2;
    resetn = 1'b1;
    mem_allowin = 1'b1;
  endtask

  task automatic test_random();
    logic        have = 1'b0;
    logic [31:0] e_res, e_wdata;
    logic [5:0]  e_excp;
    logic        e_req;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    mem_allowin       = 1'b1;
    data_sram_addr_ok = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      @(posedge clk); #1;
      if (have) begin
        n_checks++; if (exe_result !== e_res) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", i, exe_result, e_res); end
        n_checks++; if (exe_excp !== e_excp) begin n_fail++; $display("FAIL rnd_excp[%0d]: got %h want %h", i, exe_excp, e_excp); end
        n_checks++; if (data_sram_req !== e_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, data_sram_req, e_req); end
        n_checks++; if (exe_to_mem_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_to_mem[%0d]: got %b want 1", i, exe_to_mem_valid); end
        if (e_req) begin
          n_checks++; if (data_sram_wstrb !== e_wstrb || data_sram_wdata !== e_wdata || data_sram_size !== e_size)
            begin n_fail++; $display("FAIL rnd_sram[%0d]: got %b/%h/%0d want %b/%h/%0d", i, data_sram_wstrb, data_sram_wdata, data_sram_size, e_wstrb, e_wdata, e_size); end
        end
      end
      if (i < 300) begin
        int          op;
        logic [31:0] a, b, st;
        logic [1:0]  size;
        logic        we, re, ertn, ale;
        logic [5:0]  excp;
        a = $urandom; b = $urandom; st = $urandom;
        if ($urandom_range(0, 2) == 0) begin
          op = 0; b = b % 16; size = 2'($urandom_range(1, 3));
          we = $urandom_range(0, 1) == 1; re = ~we;
        end else begin
          op = $urandom_range(0, 11); size = 2'b00; we = 1'b0; re = 1'b0;
        end
        excp = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
        ertn = $urandom_range(0, 15) == 0;
        drive(op, a, b, st, size, we, re, excp, ertn);
        e_res   = ref_alu(op, a, b);
        ale     = ref_ale(size, we | re, e_res);
        e_excp  = excp | (ale ? 6'd2 : 6'd0);
        e_req   = (we | re) & ~ale & (excp == 6'd0) & ~ertn;
        e_wstrb = ref_wstrb(size, we, e_res);
        e_wdata = ref_wdata(size, st);
        e_size  = size - 2'd1;
        have    = 1'b1;
      end else begin
        idle_id();
      end
    end
    data_sram_addr_ok = 1'b0;
  endtask

  initial begin
    resetn            = 1'b0;
    mem_allowin       = 1'b1;
    mem_flush         = 1'b0;
    mem_excp_pending  = 1'b0;
    data_sram_addr_ok = 1'b0;
    id_src1           = '0;
    id_src2           = '0;
    id_st_data        = '0;
    id_pc             = '0;
    idle_id();
    test_reset();
    test_alu();
    test_store_byte();
    test_ale();
    test_back_pressure();
    test_flush_waiting();
    test_flush_after_accept();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
